// File: rtl/plab3_mem_l2_tdm_arbiter_pkg.sv
// plab3_mem_l2_tdm_arbiter_pkg: shared FSM encoding and memory message widths
`ifndef VC_MEM_REQ_MSG_NBITS
`define VC_MEM_REQ_MSG_NBITS(o_,a_,d_) (3+(o_)+(a_)+$clog2((d_)/8)+(d_))
`endif
`ifndef VC_MEM_RESP_MSG_NBITS
`define VC_MEM_RESP_MSG_NBITS(o_,d_) (3+(o_)+2+$clog2((d_)/8)+(d_))
`endif

package plab3_mem_l2_tdm_arbiter_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;
endpackage

// File: rtl/plab3_mem_l2_slot_timer.sv
// plab3_mem_l2_slot_timer: fixed-length alternating ownership slots with guard window and overrun hold
module plab3_mem_l2_slot_timer #(
    parameter int p_slot_len = 32,
    parameter int p_guard    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic resp_fire,
    output logic slot_owner,
    output logic win,
    output logic overrun
);
    localparam int cw = $clog2(p_slot_len);
    localparam logic [cw-1:0] last_v = cw'(p_slot_len - 1);
    localparam logic [cw-1:0] win_v  = cw'(p_slot_len - p_guard);

    logic [cw-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last;

    // a slot that ends with a transaction still open is stretched until the response fires
    always_comb begin
        last    = cnt_q == last_v;
        overrun = busy && last && !resp_fire;
        cnt_d   = !last ? cnt_q + 1'b1 : overrun ? cnt_q : '0;
        owner_d = (last && !overrun) ? ~owner_q : owner_q;
        win     = !busy && (cnt_q < win_v);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            owner_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    assign slot_owner = owner_q;
endmodule

// File: rtl/plab3_mem_l2_tdm_arbiter.sv
// plab3_mem_l2_tdm_arbiter: time-division arbiter sharing one blocking L2 between two security domains
module plab3_mem_l2_tdm_arbiter
    import plab3_mem_l2_tdm_arbiter_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int abw            = 32,
    parameter int clw            = 128,
    parameter int p_slot_len     = 32,
    parameter int p_guard        = 16,
    localparam int rq_nbits = `VC_MEM_REQ_MSG_NBITS(p_opaque_nbits, abw, clw),
    localparam int rs_nbits = `VC_MEM_RESP_MSG_NBITS(p_opaque_nbits, clw)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [rq_nbits-1:0] req0_msg,
    input  logic                req0_val,
    output logic                req0_rdy,
    input  logic [rq_nbits-1:0] req1_msg,
    input  logic                req1_val,
    output logic                req1_rdy,
    output logic [rs_nbits-1:0] resp0_msg,
    output logic                resp0_val,
    input  logic                resp0_rdy,
    output logic [rs_nbits-1:0] resp1_msg,
    output logic                resp1_val,
    input  logic                resp1_rdy,
    output logic [rq_nbits-1:0] cachereq_msg,
    output logic                cachereq_val,
    input  logic                cachereq_rdy,
    input  logic [rs_nbits-1:0] cacheresp_msg,
    input  logic                cacheresp_val,
    output logic                cacheresp_rdy,
    output logic                domain,
    output logic                overrun
);
    arb_state_e state_q;
    logic       owner_q, slot_owner, win, busy, req_fire, resp_fire;

    plab3_mem_l2_slot_timer #(
        .p_slot_len(p_slot_len),
        .p_guard   (p_guard)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .busy      (busy),
        .resp_fire (resp_fire),
        .slot_owner(slot_owner),
        .win       (win),
        .overrun   (overrun)
    );

    // reset gates the combinational handshakes so nothing appears ready while held
    always_comb begin
        busy          = state_q == WAIT;
        cachereq_msg  = slot_owner ? req1_msg : req0_msg;
        cachereq_val  = reset && win && (slot_owner ? req1_val : req0_val);
        req0_rdy      = reset && win && !slot_owner && cachereq_rdy;
        req1_rdy      = reset && win && slot_owner && cachereq_rdy;
        resp0_msg     = cacheresp_msg;
        resp1_msg     = cacheresp_msg;
        resp0_val     = reset && busy && !owner_q && cacheresp_val;
        resp1_val     = reset && busy && owner_q && cacheresp_val;
        cacheresp_rdy = reset && busy && (owner_q ? resp1_rdy : resp0_rdy);
        domain        = busy ? owner_q : slot_owner;
        req_fire      = cachereq_val && cachereq_rdy;
        resp_fire     = cacheresp_val && cacheresp_rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
        end else if (state_q == IDLE && req_fire) begin
            state_q <= WAIT;
            owner_q <= slot_owner;
        end else if (state_q == WAIT && resp_fire) begin
            state_q <= IDLE;
        end
    end
endmodule

// File: tb/tb_plab3_mem_l2_tdm_arbiter.sv
// tb_plab3_mem_l2_tdm_arbiter: directed scoreboard bench for the TDM L2 arbiter (slot 8, guard 3)
`ifndef VC_MEM_REQ_MSG_NBITS
`define VC_MEM_REQ_MSG_NBITS(o_,a_,d_) (3+(o_)+(a_)+$clog2((d_)/8)+(d_))
`endif
`ifndef VC_MEM_RESP_MSG_NBITS
`define VC_MEM_RESP_MSG_NBITS(o_,d_) (3+(o_)+2+$clog2((d_)/8)+(d_))
`endif

module tb_plab3_mem_l2_tdm_arbiter;
    localparam int RQW = `VC_MEM_REQ_MSG_NBITS(8, 32, 128);
    localparam int RSW = `VC_MEM_RESP_MSG_NBITS(8, 128);

    typedef struct {
        int             cyc;
        logic [RQW-1:0] msg;
        logic           dom;
    } req_t;

    logic clk = 1'b0, reset = 1'b0;
    logic [RQW-1:0] req0_msg = '0, req1_msg = '0, cachereq_msg;
    logic [RSW-1:0] resp0_msg, resp1_msg, cacheresp_msg = '0;
    logic req0_val = 1'b0, req1_val = 1'b0, req0_rdy, req1_rdy;
    logic resp0_val, resp1_val, resp0_rdy = 1'b1, resp1_rdy = 1'b1;
    logic cachereq_val, cachereq_rdy = 1'b1, cacheresp_val = 1'b0, cacheresp_rdy;
    logic domain, overrun;
    logic [7:0] outs;

    int   n_cmp = 0, n_bad = 0, cyc = 0;
    req_t rq[$];
    req_t e_r;
    logic [RSW-1:0] r0q[$], r1q[$];

    plab3_mem_l2_tdm_arbiter #(
        .p_opaque_nbits(8), .abw(32), .clw(128), .p_slot_len(8), .p_guard(3)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .cachereq_msg(cachereq_msg), .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
        .cacheresp_msg(cacheresp_msg), .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .domain(domain), .overrun(overrun)
    );

    always #5 clk = ~clk;

    assign outs = {req0_rdy, req1_rdy, cachereq_val, resp0_val, resp1_val, cacheresp_rdy, domain, overrun};

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [RQW-1:0] mk(int k);
        return RQW'({6{32'(k) * 32'h9E3779B1}});
    endfunction

    function automatic logic [RSW-1:0] mkr(int k);
        return RSW'({5{32'(k) * 32'h85EBCA6B}});
    endfunction

    task automatic chk(string n, logic [255:0] a, logic [255:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0_val = 1'b1;
        req1_val = 1'b1;
        cachereq_rdy = 1'b1;
        resp0_rdy = 1'b1;
        resp1_rdy = 1'b1;
        cacheresp_val = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outs", outs, 8'h00);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        req0_val = 1'b0;
        req1_val = 1'b0;
    endtask

    // monitor: every handshake on the cache or response side must match the next expected item
    always @(negedge clk) begin
        if (cachereq_val && cachereq_rdy) begin
            if (rq.size() == 0) chk("unexpected_issue", cyc, 256'hFFFF);
            else begin
                e_r = rq.pop_front();
                chk("issue_cycle", cyc, e_r.cyc);
                chk("issue_msg", cachereq_msg, e_r.msg);
                chk("issue_domain", domain, e_r.dom);
            end
        end
        if (resp0_val && resp0_rdy) begin
            if (r0q.size() == 0) chk("unexpected_resp0", resp0_msg, 0);
            else chk("resp0_msg", resp0_msg, r0q.pop_front());
        end
        if (resp1_val && resp1_rdy) begin
            if (r1q.size() == 0) chk("unexpected_resp1", resp1_msg, 0);
            else chk("resp1_msg", resp1_msg, r1q.pop_front());
        end
    end

    initial begin
        // reset, then req0 fires at slot_cnt 0
        do_reset();
        req0_val = 1'b1;
        req0_msg = mk(1);
        rq.push_back('{0, mk(1), 1'b0});
        tick(1);
        req0_val = 1'b0;
        cacheresp_val = 1'b1;
        cacheresp_msg = mkr(2);
        r0q.push_back(mkr(2));
        tick(1);
        cacheresp_val = 1'b0;

        // non-owner waits for its own slot; response routed to resp1 only
        do_reset();
        req1_val = 1'b1;
        req1_msg = mk(10);
        rq.push_back('{8, mk(10), 1'b1});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("req1_rdy_nonowner", req1_rdy, 0);
            tick(1);
        end
        tick(1);
        req1_val = 1'b0;
        cacheresp_val = 1'b1;
        cacheresp_msg = mkr(11);
        r1q.push_back(mkr(11));
        @(negedge clk);
        chk("resp0_val_isolated", resp0_val, 0);
        tick(1);
        cacheresp_val = 1'b0;

        // request in the guard window waits until the owner's next slot
        do_reset();
        tick(5);
        req0_val = 1'b1;
        req0_msg = mk(12);
        rq.push_back('{16, mk(12), 1'b0});
        for (int c = 5; c < 16; c++) begin
            @(negedge clk);
            chk("req0_rdy_guard", req0_rdy, 0);
            tick(1);
        end
        tick(1);
        req0_val = 1'b0;
        cacheresp_val = 1'b1;
        cacheresp_msg = mkr(13);
        r0q.push_back(mkr(13));
        tick(1);
        cacheresp_val = 1'b0;

        // back-to-back with 1-cycle L2: fires at slot_cnt 0, 2, 4 only
        do_reset();
        req0_val = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cacheresp_val = (c % 2 == 1) && (c <= 5);
            if (c % 2 == 0 && c <= 4) begin
                req0_msg = mk(20 + c);
                rq.push_back('{c, mk(20 + c), 1'b0});
            end
            if (cacheresp_val) begin
                cacheresp_msg = mkr(40 + c);
                r0q.push_back(mkr(40 + c));
            end
            if (c >= 5) begin
                @(negedge clk);
                chk("b2b_no_issue_guard", cachereq_val, 0);
            end
            tick(1);
        end
        req0_val = 1'b0;
        cacheresp_val = 1'b0;

        // overrun: issue at 4, respond at 10; slot held at 7 for cycles 7-9
        do_reset();
        tick(4);
        req0_val = 1'b1;
        req0_msg = mk(30);
        rq.push_back('{4, mk(30), 1'b0});
        tick(1);
        req0_val = 1'b0;
        for (int c = 5; c < 10; c++) begin
            @(negedge clk);
            chk("overrun_flag", overrun, (c >= 7) ? 1 : 0);
            chk("overrun_domain", domain, 0);
            tick(1);
        end
        cacheresp_val = 1'b1;
        cacheresp_msg = mkr(31);
        r0q.push_back(mkr(31));
        @(negedge clk);
        chk("overrun_release", overrun, 0);
        tick(1);
        cacheresp_val = 1'b0;
        req1_val = 1'b1;
        req1_msg = mk(32);
        rq.push_back('{11, mk(32), 1'b1});
        @(negedge clk);
        chk("toggle_after_overrun", domain, 1);
        tick(1);
        req1_val = 1'b0;
        cacheresp_val = 1'b1;
        cacheresp_msg = mkr(33);
        r1q.push_back(mkr(33));
        tick(1);
        cacheresp_val = 1'b0;

        // response backpressure, then reset while waiting
        do_reset();
        req0_val = 1'b1;
        req0_msg = mk(50);
        rq.push_back('{0, mk(50), 1'b0});
        tick(1);
        req0_val = 1'b0;
        resp0_rdy = 1'b0;
        cacheresp_val = 1'b1;
        cacheresp_msg = mkr(51);
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            chk("bp_cacheresp_rdy", cacheresp_rdy, 0);
            chk("bp_resp0_val", resp0_val, 1);
            tick(1);
        end
        reset = 1'b0;
        resp0_rdy = 1'b1;
        cacheresp_val = 1'b0;
        #1;
        chk("midreset_outs", outs, 8'h00);
        tick(2);
        reset = 1'b1;
        req0_val = 1'b1;
        req0_msg = mk(52);
        rq.push_back('{0, mk(52), 1'b0});
        tick(1);
        req0_val = 1'b0;
        cacheresp_val = 1'b1;
        cacheresp_msg = mkr(53);
        r0q.push_back(mkr(53));
        tick(1);
        cacheresp_val = 1'b0;
        tick(2);

        chk("issue_queue_drained", rq.size(), 0);
        chk("resp0_queue_drained", r0q.size(), 0);
        chk("resp1_queue_drained", r1q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
